// File: rtl/line_draw.sv
// Bresenham line engine feeding a single-pixel display write port, paced by the driver's busy state.
// Build option: define LINE_DRAW_LAST_PIXEL_EN to also draw the endpoint pixel.
module line_draw #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] x0,
    input  logic [6:0] x1,
    input  logic [5:0] y0,
    input  logic [5:0] y1,
    input  logic       color,
    output logic       busy,
    output logic       done,
    output logic       pixel,
    output logic [6:0] x,
    output logic [5:0] y,
    output logic       pixel_we,
    input  logic [1:0] pixel_state
);

    localparam int unsigned XW        = 7;
    localparam int unsigned YW        = 6;
    localparam int unsigned EW        = 10;
    localparam int unsigned CW        = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
    localparam int unsigned WAIT_LAST = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_STEP,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [XW-1:0]         r_x0, r_x1, r_x;
    logic [YW-1:0]         r_y0, r_y1, r_y;
    logic                  r_color, r_pixel, r_busy, r_done, r_we;
    logic                  r_sx, r_sy;
    logic signed [EW-1:0]  r_dx, r_dy, r_err;
    logic [CW-1:0]         r_cnt;

    logic [XW-1:0]         w_adx;
    logic [YW-1:0]         w_ady;
    logic signed [EW-1:0]  w_e2, w_nerr;
    logic [XW-1:0]         w_nx;
    logic [YW-1:0]         w_ny;

    assign busy     = r_busy;
    assign done     = r_done;
    assign pixel    = r_pixel;
    assign x        = r_x;
    assign y        = r_y;
    assign pixel_we = r_we;

    assign w_adx = (r_x1 >= r_x0) ? r_x1 - r_x0 : r_x0 - r_x1;
    assign w_ady = (r_y1 >= r_y0) ? r_y1 - r_y0 : r_y0 - r_y1;
    assign w_e2  = r_err <<< 1;

    // One Bresenham step; both axis tests use the same pre-update e2.
    always_comb begin
        w_nx   = r_x;
        w_ny   = r_y;
        w_nerr = r_err;
        if (w_e2 >= r_dy) begin
            w_nerr = w_nerr + r_dy;
            w_nx   = r_sx ? r_x - XW'(1) : r_x + XW'(1);
        end
        if (w_e2 <= r_dx) begin
            w_nerr = w_nerr + r_dx;
            w_ny   = r_sy ? r_y - YW'(1) : r_y + YW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= 1'b0;
            r_pixel <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x0    <= x0;
                        r_x1    <= x1;
                        r_y0    <= y0;
                        r_y1    <= y1;
                        r_color <= color;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_x     <= r_x0;
                    r_y     <= r_y0;
                    r_pixel <= r_color;
                    r_sx    <= (r_x1 < r_x0);
                    r_sy    <= (r_y1 < r_y0);
                    r_dx    <= EW'(w_adx);
                    r_dy    <= EW'(0) - EW'(w_ady);
                    r_err   <= EW'(w_adx) - EW'(w_ady);
`ifdef LINE_DRAW_LAST_PIXEL_EN
                    r_state <= S_ISSUE;
`else
                    // Zero-length line draws nothing when the endpoint is excluded.
                    if (r_x0 == r_x1 && r_y0 == r_y1) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_ISSUE;
                    end
`endif
                end
                S_ISSUE: begin
                    if (pixel_state == 2'b00) begin
                        r_we    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt < CW'(WAIT_LAST)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else if (pixel_state == 2'b00) begin
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
`ifdef LINE_DRAW_LAST_PIXEL_EN
                    if (r_x == r_x1 && r_y == r_y1) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_x     <= w_nx;
                        r_y     <= w_ny;
                        r_err   <= w_nerr;
                        r_state <= S_ISSUE;
                    end
`else
                    // Endpoint test looks ahead so the endpoint itself is never issued.
                    r_x   <= w_nx;
                    r_y   <= w_ny;
                    r_err <= w_nerr;
                    if (w_nx == r_x1 && w_ny == r_y1) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_ISSUE;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_draw.sv
// Randomised and directed bench for line_draw against an integer Bresenham model and a busy-driver model.
module tb_line_draw;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] x0, x1;
    logic [5:0] y0, y1;
    logic       color;
    logic       busy, done, pixel, pixel_we;
    logic [6:0] x;
    logic [5:0] y;
    logic [1:0] pixel_state;

    line_draw #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .busy(busy), .done(done), .pixel(pixel), .x(x), .y(y),
        .pixel_we(pixel_we), .pixel_state(pixel_state)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          drv_cnt = 0;
    int          busy_len = 0;
    logic        hold_ps = 1'b0;
    logic [13:0] obs_q[$];
    int          obs_cyc[$];
    logic [13:0] exp_q[$];
    int          n_done_tot = 0;
    int          viol_gap = 0;
    int          viol_idle = 0;
    logic        prev_we = 1'b0;

    // Driver model: busy for busy_len cycles after each accepted write, or while forced.
    assign pixel_state = (drv_cnt != 0 || hold_ps) ? 2'b01 : 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst)              drv_cnt <= 0;
        else if (pixel_we)    drv_cnt <= busy_len;
        else if (drv_cnt > 0) drv_cnt <= drv_cnt - 1;
    end

    always @(negedge clk) begin
        if (pixel_we) begin
            obs_q.push_back({pixel, x, y});
            obs_cyc.push_back(cyc);
            if (prev_we) viol_gap <= viol_gap + 1;
            if (pixel_state != 2'b00) viol_idle <= viol_idle + 1;
        end
        if (done) n_done_tot <= n_done_tot + 1;
        prev_we <= pixel_we;
    end

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference: integer Bresenham walk from the endpoint rules.
    task automatic build_exp(input int ax0, input int ay0, input int ax1, input int ay1, input bit col);
        int dx, dy, sx, sy, err, e2, px, py;
        exp_q.delete();
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        px  = ax0;
        py  = ay0;
        forever begin
            exp_q.push_back({col, 7'(px), 6'(py)});
            if (px == ax1 && py == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; px += sx; end
            if (e2 <= dx) begin err += dx; py += sy; end
        end
`ifndef LINE_DRAW_LAST_PIXEL_EN
        void'(exp_q.pop_back());
`endif
    endtask

    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input bit col, input int lat, input bit poke, input bit hold);
        int s, c, n, base, gap_base, idle_base, done_base, lim, hend;
        bit timed, held;
        build_exp(ax0, ay0, ax1, ay1, col);
        n         = exp_q.size();
        busy_len  = lat;
        base      = obs_q.size();
        gap_base  = viol_gap;
        idle_base = viol_idle;
        done_base = n_done_tot;
        timed     = (lat == 0) && !hold;
        held      = 1'b0;
        hend      = 0;
        lim       = 40 + n * (lat + 6) + (hold ? 30 : 0);
        tick();
        x0 = 7'(ax0); y0 = 6'(ay0); x1 = 7'(ax1); y1 = 6'(ay1); color = col;
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        x0 = 7'($urandom); y0 = 6'($urandom); x1 = 7'($urandom); y1 = 6'($urandom); color = ~col;
        check("busy_rise", int'(busy), 1);
        c = 1;
        while (!done && c < lim) begin
            tick();
            c++;
            start = poke && (c == 4);
            if (hold && !held && (obs_q.size() - base >= 2) && cyc > obs_cyc[base + 1]) begin
                hold_ps = 1'b1;
                held    = 1'b1;
                hend    = cyc + 20;
            end
            if (hold_ps && cyc >= hend) hold_ps = 1'b0;
        end
        start   = 1'b0;
        hold_ps = 1'b0;
        check("done_seen", int'(done), 1);
        check("busy_at_done", int'(busy), 0);
        if (timed) check("done_cycle", c, 4 * n + 2);
        tick();
        tick();
        check("done_pulses", n_done_tot - done_base, 1);
        check("strobe_count", obs_q.size() - base, n);
        for (int i = 0; i < n && base + i < obs_q.size(); i++)
            check("pixel_xy", int'(obs_q[base + i]), int'(exp_q[i]));
        if (timed && n > 0 && obs_cyc.size() > base) begin
            check("first_we", obs_cyc[base] - s, 3);
            for (int i = 1; i < n && base + i < obs_cyc.size(); i++)
                check("we_period", obs_cyc[base + i] - obs_cyc[base + i - 1], 4);
        end
        check("we_back2back", viol_gap - gap_base, 0);
        check("we_while_busy", viol_idle - idle_base, 0);
    endtask

    initial begin
        int base, c, ax0, ay0, ax1, ay1, lat;
        rst = 1'b0; start = 1'b0; color = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(pixel_we), 0);
        check("rst_pixel", int'(pixel), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Directed lines
        run_line(0, 0, 3, 0, 1'b1, 3, 1'b0, 1'b0);
        run_line(0, 0, 3, 0, 1'b1, 0, 1'b0, 1'b0);
        run_line(0, 0, 2, 5, 1'b1, 0, 1'b0, 1'b0);
        run_line(5, 3, 2, 3, 1'b0, 0, 1'b0, 1'b0);
        run_line(10, 10, 7, 13, 1'b1, 2, 1'b0, 1'b0);
        run_line(4, 4, 4, 4, 1'b1, 0, 1'b0, 1'b0);
        run_line(0, 0, 9, 4, 1'b1, 1, 1'b1, 1'b1);
        run_line(127, 63, 120, 50, 1'b1, 0, 1'b1, 1'b0);

        // Reset in the middle of a long line
        busy_len = 0;
        base = obs_q.size();
        tick();
        x0 = 7'd0; y0 = 6'd0; x1 = 7'd127; y1 = 6'd0; color = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (obs_q.size() - base < 2 && c < 100) begin
            tick();
            c++;
        end
        check("rst_pre_strobes", obs_q.size() - base, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_we", int'(pixel_we), 0);
        check("mid_rst_pixel", int'(pixel), 0);
        check("mid_rst_x", int'(x), 0);
        check("mid_rst_y", int'(y), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        run_line(1, 1, 1, 1, 1'b1, 0, 1'b0, 1'b0);

        // Random short lines
        for (int i = 0; i < 25; i++) begin
            ax0 = int'($urandom_range(0, 127));
            ay0 = int'($urandom_range(0, 63));
            if (i % 8 == 0) begin
                ax1 = ax0;
                ay1 = ay0;
            end else begin
                ax1 = clamp(ax0 + int'($urandom_range(0, 30)) - 15, 127);
                ay1 = clamp(ay0 + int'($urandom_range(0, 30)) - 15, 63);
            end
            lat = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4));
            run_line(ax0, ay0, ax1, ay1, 1'($urandom), lat, 1'($urandom), (i % 6 == 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
